// File: rtl/branch_ctrl_pkg.sv
// branch_ctrl_pkg: shared MIPS branch opcode / REGIMM rt constants, the
// branch-resolution FSM state type, and small decode helpers used by
// branch_ctrl.
package branch_ctrl_pkg;

  // Primary opcodes
  localparam logic [5:0] EXE_BEQ         = 6'b000100;
  localparam logic [5:0] EXE_BNE         = 6'b000101;
  localparam logic [5:0] EXE_BLEZ        = 6'b000110;
  localparam logic [5:0] EXE_BGTZ        = 6'b000111;
  localparam logic [5:0] EXE_REGIMM_INST = 6'b000001;

  // REGIMM sub-ops carried in the rt field
  localparam logic [4:0] EXE_BLTZ   = 5'b00000;
  localparam logic [4:0] EXE_BGEZ   = 5'b00001;
  localparam logic [4:0] EXE_BLTZAL = 5'b10000;
  localparam logic [4:0] EXE_BGEZAL = 5'b10001;

  localparam logic [31:0] ZeroWord = 32'h0000_0000;

  typedef enum logic {
    BR_IDLE = 1'b0,
    BR_WAIT = 1'b1
  } br_state_e;

  // True for every instruction this block resolves.
  function automatic logic is_branch(input logic [5:0] op, input logic [4:0] rt);
    logic res;
    case (op)
      EXE_BEQ, EXE_BNE, EXE_BLEZ, EXE_BGTZ: res = 1'b1;
      EXE_REGIMM_INST: res = (rt == EXE_BLTZ) || (rt == EXE_BGEZ) ||
                             (rt == EXE_BLTZAL) || (rt == EXE_BGEZAL);
      default: res = 1'b0;
    endcase
    return res;
  endfunction

  // Only the two-register compares depend on rt.
  function automatic logic needs_rt(input logic [5:0] op);
    return (op == EXE_BEQ) || (op == EXE_BNE);
  endfunction

  // Branch-and-link forms write $31.
  function automatic logic is_link(input logic [5:0] op, input logic [4:0] rt);
    return (op == EXE_REGIMM_INST) && ((rt == EXE_BLTZAL) || (rt == EXE_BGEZAL));
  endfunction

endpackage

// File: rtl/branch_ctrl_sat_counter.sv
// sat_counter: W-bit up counter that sticks at all-ones.
// Ports: clk (clock), clr (synchronous clear, wins over inc),
//        inc (count enable), q (current count).
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: clear, saturating increment, or hold.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
  end

  assign q = cnt_q;

endmodule

// File: rtl/branch_ctrl.sv
// branch_ctrl: ID-stage branch resolution sequencer.
// Waits (stalling ID) until the operands feeding the external eqcmp are
// valid, then resolves the branch: registered PC redirect when taken, $31
// link write for BLTZAL/BGEZAL, delay-slot tracking and saturating counters.
// Ports: clk/rst (sync active-high); id_valid/id_op/id_rt/id_pc describe the
//   ID instruction; branch_target precomputed target; rs_ready/rt_ready
//   forwarding status; cmp_y eqcmp result; stall_in downstream freeze;
//   flush exception flush. Outputs stall_id, redirect_valid/redirect_pc,
//   link_we/link_addr, in_delay_slot, branch_cnt/taken_cnt/stall_cnt.
module branch_ctrl
  import branch_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [5:0]       id_op,
  input  logic [4:0]       id_rt,
  input  logic [31:0]      id_pc,
  input  logic [31:0]      branch_target,
  input  logic             rs_ready,
  input  logic             rt_ready,
  input  logic             cmp_y,
  input  logic             stall_in,
  input  logic             flush,
  output logic             stall_id,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic             link_we,
  output logic [31:0]      link_addr,
  output logic             in_delay_slot,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] taken_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  br_state_e   state_q, state_d;
  logic        redirect_valid_q, redirect_valid_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;
  logic        delay_slot_q, delay_slot_d;

  logic br_present;
  logic ops_ready;
  logic resolve;
  logic taken;

  // Decode, operand readiness, FSM next state and combinational outputs.
  always_comb begin
    br_present = id_valid && is_branch(id_op, id_rt);
    ops_ready  = rs_ready && (!needs_rt(id_op) || rt_ready);
    // Same resolve condition in both states; flush and stall_in block it.
    resolve    = br_present && ops_ready && !stall_in && !flush;
    taken      = resolve && cmp_y;
    state_d    = state_q;
    stall_id   = 1'b0;
    case (state_q)
      BR_IDLE: begin
        stall_id = br_present && !ops_ready;
        // stall_in freezes the FSM, so WAIT is entered only when unstalled.
        if (br_present && !ops_ready && !stall_in && !flush) begin
          state_d = BR_WAIT;
        end else begin
          state_d = BR_IDLE;
        end
      end
      BR_WAIT: begin
        stall_id = !resolve;
        if (flush || resolve) begin
          state_d = BR_IDLE;
        end else begin
          state_d = BR_WAIT;
        end
      end
      default: begin
        stall_id = 1'b0;
        state_d  = BR_IDLE;
      end
    endcase

    redirect_valid_d = taken;
    redirect_pc_d    = taken ? branch_target : redirect_pc_q;

    // Delay-slot flag survives downstream stalls, clears on next free cycle.
    if (flush) begin
      delay_slot_d = 1'b0;
    end else if (resolve) begin
      delay_slot_d = 1'b1;
    end else if (stall_in) begin
      delay_slot_d = delay_slot_q;
    end else begin
      delay_slot_d = 1'b0;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= BR_IDLE;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= ZeroWord;
      delay_slot_q     <= 1'b0;
    end else begin
      state_q          <= state_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      delay_slot_q     <= delay_slot_d;
    end
  end

  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign in_delay_slot  = delay_slot_q;
  assign link_we        = resolve && is_link(id_op, id_rt);
  assign link_addr      = id_pc + 32'd8;

  sat_counter #(.W(CNT_W)) u_branch_cnt (
    .clk (clk), .clr (rst), .inc (resolve), .q (branch_cnt)
  );

  sat_counter #(.W(CNT_W)) u_taken_cnt (
    .clk (clk), .clr (rst), .inc (taken), .q (taken_cnt)
  );

  // Every WAIT cycle counts, except a flush cycle.
  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk), .clr (rst), .inc ((state_q == BR_WAIT) && !flush), .q (stall_cnt)
  );

endmodule

// File: tb/tb_branch_ctrl.sv
// Scoreboard bench for branch_ctrl (CNT_W=4 so saturation is reachable).
module tb_branch_ctrl;

  localparam int CW  = 4;
  localparam int SAT = 15;

  localparam logic [5:0] OP_BEQ = 6'd4, OP_BNE = 6'd5, OP_BLEZ = 6'd6, OP_BGTZ = 6'd7;
  localparam logic [5:0] OP_REGIMM = 6'd1, OP_ADDI = 6'd8, OP_LW = 6'd35;
  localparam logic [4:0] RT_BLTZ = 5'd0, RT_BGEZ = 5'd1, RT_BLTZAL = 5'd16, RT_BGEZAL = 5'd17;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, id_valid, rs_ready, rt_ready, cmp_y, stall_in, flush;
  logic [5:0] id_op;
  logic [4:0] id_rt;
  logic [31:0] id_pc, branch_target;
  logic stall_id, redirect_valid, link_we, in_delay_slot;
  logic [31:0] redirect_pc, link_addr;
  logic [CW-1:0] branch_cnt, taken_cnt, stall_cnt;

  branch_ctrl #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_op(id_op), .id_rt(id_rt),
    .id_pc(id_pc), .branch_target(branch_target), .rs_ready(rs_ready),
    .rt_ready(rt_ready), .cmp_y(cmp_y), .stall_in(stall_in), .flush(flush),
    .stall_id(stall_id), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .link_we(link_we), .link_addr(link_addr), .in_delay_slot(in_delay_slot),
    .branch_cnt(branch_cnt), .taken_cnt(taken_cnt), .stall_cnt(stall_cnt)
  );

  typedef struct {
    logic v; logic [5:0] op; logic [4:0] rt; logic [31:0] pc, tgt;
    logic rs, rtr, cmp, stl, fl, r;
  } stim_t;

  typedef struct {
    logic sid, lwe, rv, ds; logic [31:0] la, rpc; int bc, tc, sc;
  } exp_t;

  exp_t sb[$];
  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: architectural meaning, not RTL encoding.
  bit m_waiting, m_rv, m_ds;
  logic [31:0] m_rpc;
  int m_bc, m_tc, m_sc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit is_br(input logic [5:0] op, input logic [4:0] rt);
    if (op inside {OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ}) return 1'b1;
    if (op == OP_REGIMM && (rt inside {RT_BLTZ, RT_BGEZ, RT_BLTZAL, RT_BGEZAL})) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int sat_inc(input int x);
    return (x >= SAT) ? SAT : x + 1;
  endfunction

  function automatic void model_reset();
    m_waiting = 1'b0; m_rv = 1'b0; m_ds = 1'b0; m_rpc = 32'h0;
    m_bc = 0; m_tc = 0; m_sc = 0;
  endfunction

  function automatic stim_t idle_s();
    stim_t s;
    s = '{v:1'b0, op:6'd0, rt:5'd0, pc:32'h0, tgt:32'h0,
          rs:1'b0, rtr:1'b0, cmp:1'b0, stl:1'b0, fl:1'b0, r:1'b0};
    return s;
  endfunction

  function automatic stim_t br_s(input logic [5:0] op, input logic [4:0] rt,
                                 input logic [31:0] pc, input logic [31:0] tgt,
                                 input logic rs, input logic rtr, input logic cmp);
    stim_t s;
    s = idle_s();
    s.v = 1'b1; s.op = op; s.rt = rt; s.pc = pc; s.tgt = tgt;
    s.rs = rs; s.rtr = rtr; s.cmp = cmp;
    return s;
  endfunction

  // Apply one cycle of stimulus, push this cycle's expectation, advance model.
  task automatic step(input stim_t s);
    exp_t e;
    bit br, rdy, go, lnk;
    @(posedge clk);
    #1;
    id_valid = s.v; id_op = s.op; id_rt = s.rt; id_pc = s.pc; branch_target = s.tgt;
    rs_ready = s.rs; rt_ready = s.rtr; cmp_y = s.cmp; stall_in = s.stl;
    flush = s.fl; rst = s.r;

    br  = s.v && is_br(s.op, s.rt);
    rdy = s.rs && (((s.op != OP_BEQ) && (s.op != OP_BNE)) || s.rtr);
    go  = br && rdy && !s.stl && !s.fl;
    lnk = (s.op == OP_REGIMM) && (s.rt == RT_BLTZAL || s.rt == RT_BGEZAL);

    e.sid = m_waiting ? !go : (br && !rdy);
    e.lwe = go && lnk;
    e.la  = s.pc + 32'd8;
    e.rv  = m_rv; e.rpc = m_rpc; e.ds = m_ds;
    e.bc  = m_bc; e.tc = m_tc; e.sc = m_sc;
    sb.push_back(e);

    if (s.r) begin
      model_reset();
    end else begin
      if (m_waiting && !s.fl) m_sc = sat_inc(m_sc);
      if (go) m_bc = sat_inc(m_bc);
      if (go && s.cmp) begin
        m_tc = sat_inc(m_tc);
        m_rpc = s.tgt;
      end
      m_rv = go && s.cmp;
      m_ds = s.fl ? 1'b0 : (go ? 1'b1 : (s.stl ? m_ds : 1'b0));
      m_waiting = s.fl ? 1'b0 : (m_waiting ? !go : (br && !rdy && !s.stl));
    end
  endtask

  task automatic do_reset();
    stim_t s;
    s = idle_s();
    s.r = 1'b1;
    step(s);
  endtask

  // Monitor: outputs are presented every cycle; compare against queue head.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("stall_id", {31'd0, stall_id}, {31'd0, e.sid});
      chk("link_we", {31'd0, link_we}, {31'd0, e.lwe});
      chk("link_addr", link_addr, e.la);
      chk("redirect_valid", {31'd0, redirect_valid}, {31'd0, e.rv});
      chk("redirect_pc", redirect_pc, e.rpc);
      chk("in_delay_slot", {31'd0, in_delay_slot}, {31'd0, e.ds});
      chk("branch_cnt", {28'd0, branch_cnt}, e.bc);
      chk("taken_cnt", {28'd0, taken_cnt}, e.tc);
      chk("stall_cnt", {28'd0, stall_cnt}, e.sc);
    end
  end

  logic [5:0] op_tab [8];
  logic [4:0] rt_tab [5];

  initial begin
    stim_t s;
    op_tab = '{OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ, OP_REGIMM, OP_REGIMM, OP_ADDI, OP_LW};
    rt_tab = '{RT_BLTZ, RT_BGEZ, RT_BLTZAL, RT_BGEZAL, 5'd5};
    rst = 1'b1; id_valid = 1'b0; id_op = 6'd0; id_rt = 5'd0; id_pc = 32'h0;
    branch_target = 32'h0; rs_ready = 1'b0; rt_ready = 1'b0; cmp_y = 1'b0;
    stall_in = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clk);
    model_reset();

    // Taken BEQ, operands ready
    step(br_s(OP_BEQ, 5'd0, 32'h0040_0010, 32'h0040_0040, 1'b1, 1'b1, 1'b1));
    #1 chk("t1_no_stall", {31'd0, stall_id}, 32'd0);
    step(idle_s());
    #1;
    chk("t1_rv", {31'd0, redirect_valid}, 32'd1);
    chk("t1_rpc", redirect_pc, 32'h0040_0040);
    chk("t1_ds", {31'd0, in_delay_slot}, 32'd1);
    chk("t1_bc", {28'd0, branch_cnt}, 32'd1);
    chk("t1_tc", {28'd0, taken_cnt}, 32'd1);

    // BNE waiting two cycles on rt, not taken
    do_reset();
    repeat (2) step(br_s(OP_BNE, 5'd0, 32'h0040_0020, 32'h0040_0080, 1'b1, 1'b0, 1'b0));
    step(br_s(OP_BNE, 5'd0, 32'h0040_0020, 32'h0040_0080, 1'b1, 1'b1, 1'b0));
    step(idle_s());
    #1;
    chk("t2_sc", {28'd0, stall_cnt}, 32'd2);
    chk("t2_rv", {31'd0, redirect_valid}, 32'd0);
    chk("t2_bc", {28'd0, branch_cnt}, 32'd1);
    chk("t2_tc", {28'd0, taken_cnt}, 32'd0);

    // BGEZAL not taken still links
    step(br_s(OP_REGIMM, RT_BGEZAL, 32'h0040_0100, 32'h0040_0200, 1'b1, 1'b0, 1'b0));
    #1;
    chk("t3_lwe", {31'd0, link_we}, 32'd1);
    chk("t3_la", link_addr, 32'h0040_0108);

    // Flush in the cycle operands become ready
    do_reset();
    step(br_s(OP_BEQ, 5'd0, 32'h0040_0300, 32'h0040_0400, 1'b1, 1'b0, 1'b1));
    s = br_s(OP_BEQ, 5'd0, 32'h0040_0300, 32'h0040_0400, 1'b1, 1'b1, 1'b1);
    s.fl = 1'b1;
    step(s);
    step(idle_s());
    #1;
    chk("t4_rv", {31'd0, redirect_valid}, 32'd0);
    chk("t4_bc", {28'd0, branch_cnt}, 32'd0);
    chk("t4_idle", {31'd0, stall_id}, 32'd0);

    // Delay slot held across downstream stall
    step(br_s(OP_BGTZ, 5'd0, 32'h0040_0500, 32'h0040_0600, 1'b1, 1'b0, 1'b0));
    s = idle_s();
    s.stl = 1'b1;
    repeat (3) begin
      step(s);
      #1 chk("t5_ds_held", {31'd0, in_delay_slot}, 32'd1);
    end
    step(idle_s());
    step(idle_s());
    #1 chk("t5_ds_clr", {31'd0, in_delay_slot}, 32'd0);

    // Saturation at 15 then reset clears
    do_reset();
    for (int i = 0; i < 17; i++)
      step(br_s(OP_BEQ, 5'd0, 32'h0040_1000 + 32'(i * 4), 32'h0040_2000, 1'b1, 1'b1, 1'b1));
    step(idle_s());
    #1;
    chk("t6_tc_sat", {28'd0, taken_cnt}, 32'd15);
    chk("t6_bc_sat", {28'd0, branch_cnt}, 32'd15);
    do_reset();
    step(idle_s());
    #1;
    chk("t6_bc_rst", {28'd0, branch_cnt}, 32'd0);
    chk("t6_tc_rst", {28'd0, taken_cnt}, 32'd0);
    chk("t6_sc_rst", {28'd0, stall_cnt}, 32'd0);

    // Random traffic; ID holds its instruction while the model is waiting
    s = idle_s();
    for (int i = 0; i < 3000; i++) begin
      if (!m_waiting) begin
        s.v   = ($urandom_range(0, 3) != 0);
        s.op  = op_tab[$urandom_range(0, 7)];
        s.rt  = rt_tab[$urandom_range(0, 4)];
        s.pc  = {$urandom(), 2'b00} & 32'h00FF_FFFC;
        s.tgt = {$urandom(), 2'b00} & 32'h00FF_FFFC;
      end
      s.rs  = ($urandom_range(0, 2) != 0);
      s.rtr = ($urandom_range(0, 2) != 0);
      s.cmp = $urandom_range(0, 1) == 1;
      s.stl = ($urandom_range(0, 4) == 0);
      s.fl  = ($urandom_range(0, 19) == 0);
      s.r   = ($urandom_range(0, 299) == 0);
      step(s);
    end
    step(idle_s());
    @(negedge clk);
    #1;
    chk("sb_drained", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_ctrl.md
Name: branch_ctrl

Overview:
- Sequences branch resolution in the ID stage of the 5-stage MIPS core.
- Decides when the existing eqcmp comparator result may be trusted (operands forwarded and ready). Stalls ID until then.
- Issues a registered PC redirect and the $31 link write for BGEZAL/BLTZAL, and tracks the delay slot.
- Keeps saturating branch performance counters.

Parameters:
- CNT_W, 32, width of each performance counter (saturating).

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  ID holds a valid instruction
- id_op  in  6  opcode of ID instruction
- id_rt  in  5  rt field (REGIMM sub-op)
- id_pc  in  32  PC of ID instruction
- branch_target  in  32  precomputed target (id_pc+4+(sext imm<<2))
- rs_ready  in  1  rs value valid on forwarding path this cycle
- rt_ready  in  1  rt value valid on forwarding path this cycle
- cmp_y  in  1  eqcmp result for current ID operands
- stall_in  in  1  downstream stall (ID frozen)
- flush  in  1  exception/ERET flush
- stall_id  out  1  freeze PC/IF/ID; bubble into EX
- redirect_valid  out  1  one-cycle pulse: PC <= redirect_pc
- redirect_pc  out  32  branch target
- link_we  out  1  write $31 (pulse, same cycle as resolve)
- link_addr  out  32  id_pc+8
- in_delay_slot  out  1  instruction now entering ID is a delay slot
- branch_cnt  out  CNT_W  resolved branches
- taken_cnt  out  CNT_W  taken branches
- stall_cnt  out  CNT_W  cycles stalled waiting operands

Behaviour:
- Branch decode: BEQ, BNE, BGTZ, BLEZ, and REGIMM with rt in {BLTZ, BGEZ, BLTZAL, BGEZAL}. All other instructions are non-branches.
- Operand requirements: BEQ/BNE need rs_ready and rt_ready. All other branches need rs_ready only.
- FSM states:
  - IDLE. Entered at reset.
    - If id_valid, is branch, operands not ready, no flush: go to WAIT.
    - If id_valid, is branch, operands ready, !stall_in, no flush: resolve this cycle, stay IDLE.
  - WAIT.
    - stall_id=1 combinationally every cycle.
    - stall_cnt increments per cycle.
    - Once operands are ready and !stall_in: resolve and go to IDLE.
- stall_id is combinational: high in IDLE when a branch is present and operands are not ready, and in WAIT until the resolve cycle (low in the resolve cycle).
- Resolve cycle:
  - branch_cnt increments.
  - link_we=1 combinationally if BGEZAL/BLTZAL, regardless of taken. link_addr=id_pc+8.
  - If cmp_y: taken_cnt increments, and redirect_pc<=branch_target registered, redirect_valid=1 for exactly the next cycle.
- Latency: resolve to redirect is 1 cycle. Fetch of the delay slot overlaps the resolve cycle. PC redirect applies after the delay slot.
- in_delay_slot: registered. Set the cycle after a resolve (taken or not). Held while stall_in=1. Cleared on the first non-stalled cycle.
- stall_in=1 in IDLE/WAIT: no resolve, no counter change except stall_cnt (WAIT only). State holds.
- flush=1: highest priority. Next cycle state=IDLE, redirect_valid=0, in_delay_slot=0. No resolve or count in the flush cycle. link_we=0 in that cycle. Counters keep their values.
- Counters saturate at 2^CNT_W-1. Cleared only by rst.
- Reset values: state IDLE; redirect_valid 0; redirect_pc 0; in_delay_slot 0; all counters 0. stall_id and link_we are combinational and 0 with no valid branch.
- Back-to-back branch in the delay slot: treated as a normal branch (architecturally undefined). No special handling; counters count both.

Decomposition:
- Opcode/rt constants (EXE_BEQ, EXE_BNE, EXE_BGTZ, EXE_BLEZ, EXE_REGIMM_INST, EXE_BLTZ, EXE_BGEZ, EXE_BLTZAL, EXE_BGEZAL) and ZeroWord come from defines.vh.
- Add to defines.vh: state encodings BR_IDLE=1'b0, BR_WAIT=1'b1.
- Sub-module sat_counter (parameter W; inc, clr, q) instantiated three times.
- eqcmp stays outside. Its y drives cmp_y.

Test Plan:
- BEQ at id_pc=0x00400010, target 0x00400040, ready, cmp_y=1 -> stall_id=0; next cycle redirect_valid=1, redirect_pc=0x00400040, in_delay_slot=1; branch_cnt=1, taken_cnt=1.
- BNE, rt_ready=0 for 2 cycles then 1, cmp_y=0 -> stall_id high 2 cycles; stall_cnt=2; no redirect; branch_cnt=1, taken_cnt=0.
- BGEZAL at id_pc=0x00400100, ready, cmp_y=0 -> link_we=1, link_addr=0x00400108, no redirect.
- Branch in WAIT, flush asserted in the same cycle operands become ready -> no redirect, branch_cnt unchanged, state IDLE next cycle.
- Resolve followed by stall_in=1 for 3 cycles -> in_delay_slot held 1 for all 3 cycles, drops on the first unstalled cycle.
- CNT_W=4, 17 taken branches -> taken_cnt=15 and branch_cnt=15 (saturated); rst -> all counters 0.
